tanh_datapath: RTL

- Datapath stage directly downstream of the tanh control unit (cntrlunt); consumes its select/load/count strobes and returns the Co and Oe status bits.
- Evaluates the truncated Taylor series tanh(x) = x - x^3/3 + 2x^5/15 - 17x^7/315 + 62x^9/2835.
- Uses a term register T, a square register Q, an accumulator E, a term counter and a 4-entry ratio ROM.
- Result is held in E and is valid whenever the controller asserts ready.

---
 rtl/tanh_datapath.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/tanh_datapath.sv
// tanh_datapath -- Taylor-series tanh datapath driven by the tanh control unit.
//
// Evaluates tanh(x) = x - x^3/3 + 2x^5/15 - 17x^7/315 + 62x^9/2835 by keeping
// the running term in T, x^2 in Q and the partial sum in E. Each iteration
// advances T by T*Q then T*ROM[cnt], where the ROM holds the ratio between
// successive coefficients. E then alternately subtracts and adds T.
//
// Optional build macro: TANH_SAT_EN. When it is defined, multiplier and adder
// results clamp to the signed WIDTH range. When it is undefined, they wrap.
//
// Ports:
//   Clk     clock, rising edge
//   Rst     synchronous active-high reset (clears Q, T, E, cnt)
//   X       signed operand, QI.FRAC
//   in0     init: cnt <= 0; X is the T/E source
//   inc     term counter increment
//   ldq/ldt/lde   load strobes for Q / T / E
//   selx    T/E source = X (Q always loads X*X)
//   selq    multiplier B = Q (priority over selrom)
//   selrom  multiplier B = ROM[cnt]
//   selt    multiplier A = T
//   selm    T source = multiplier
//   sela    E source = adder/subtractor
//   sub     adder computes E - T
//   Co      cnt == 3 (last term)
//   Oe      cnt[0] (term parity)
//   Result  contents of E

// Signed fixed-point multiply: (a*b) >>> FRAC, then wrap or clamp to WIDTH.
module tanh_mul #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 14
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] shr;

  assign prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  // Arithmetic shift truncates toward -inf.
  assign shr  = prod >>> FRAC;

`ifdef TANH_SAT_EN
  localparam logic signed [2*WIDTH-1:0] PMAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] PMIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  always_comb begin
    p = WIDTH'(shr);
    if (shr > PMAX)      p = {1'b0, {(WIDTH-1){1'b1}}};
    else if (shr < PMIN) p = {1'b1, {(WIDTH-1){1'b0}}};
  end
`else
  assign p = WIDTH'(shr);
`endif
endmodule

module tanh_datapath #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 14
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] X,
  input  logic             in0,
  input  logic             inc,
  input  logic             ldq,
  input  logic             ldt,
  input  logic             lde,
  input  logic             selx,
  input  logic             selq,
  input  logic             selrom,
  input  logic             selt,
  input  logic             selm,
  input  logic             sela,
  input  logic             sub,
  output logic             Co,
  output logic             Oe,
  output logic [WIDTH-1:0] Result
);
  // Lane 0 is the shared term multiplier and lane 1 is the dedicated X*X squarer.
  // Q and T can then both load in the same cycle.
  localparam int NUM_MUL = 2;

  logic signed [WIDTH-1:0] q, t, e;
  logic        [1:0]       cnt;
  logic signed [WIDTH-1:0] rom;

  logic [NUM_MUL-1:0][WIDTH-1:0] mul_a, mul_b, mul_p;

  // Ratio ROM: magnitude of c[n+1]/c[n] in QI.14.
  always_comb begin
    rom = '0;
    case (cnt)
      2'd0: rom = WIDTH'(5461);  // 1/3
      2'd1: rom = WIDTH'(6554);  // 2/5
      2'd2: rom = WIDTH'(6632);  // 17/42
      2'd3: rom = WIDTH'(6639);  // 62/153
      default: rom = '0;
    endcase
  end

  always_comb begin
    mul_a[0] = selt ? t : X;
    mul_b[0] = selq ? q : (selrom ? rom : X);
    mul_a[1] = X;
    mul_b[1] = X;
  end

  for (genvar i = 0; i < NUM_MUL; i++) begin : g_mul
    tanh_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (
      .a(mul_a[i]),
      .b(mul_b[i]),
      .p(mul_p[i])
    );
  end

  // E +/- T computed one bit wider so overflow can be seen for the clamp.
  logic signed [WIDTH:0]   sum;
  logic signed [WIDTH-1:0] addo;

  assign sum = sub ? ($signed({e[WIDTH-1], e}) - $signed({t[WIDTH-1], t}))
                   : ($signed({e[WIDTH-1], e}) + $signed({t[WIDTH-1], t}));

`ifdef TANH_SAT_EN
  localparam logic signed [WIDTH:0] AMAX = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0] AMIN = {2'b11, {(WIDTH-1){1'b0}}};
  always_comb begin
    addo = WIDTH'(sum);
    if (sum > AMAX)      addo = {1'b0, {(WIDTH-1){1'b1}}};
    else if (sum < AMIN) addo = {1'b1, {(WIDTH-1){1'b0}}};
  end
`else
  assign addo = WIDTH'(sum);
`endif

  // in0 also selects X. The INIT cycle then loads T and E from X without
  // depending on selx.
  logic srcx;
  assign srcx = selx | in0;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      q   <= '0;
      t   <= '0;
      e   <= '0;
      cnt <= '0;
    end else begin
      if (ldq) q <= $signed(mul_p[1]);
      if (ldt) begin
        if (srcx)      t <= $signed(X);
        else if (selm) t <= $signed(mul_p[0]);
      end
      if (lde) begin
        if (srcx)      e <= $signed(X);
        else if (sela) e <= addo;
      end
      if (in0)      cnt <= '0;
      else if (inc) cnt <= cnt + 2'd1;
    end
  end

  assign Co     = (cnt == 2'd3);
  assign Oe     = cnt[0];
  assign Result = e;
endmodule
